// File: rtl/edge_counter_multi.sv
// ---------------------------------------------------------------------------
// edge_counter_multi
//
// Multi-channel gated rising-edge counter. Each of NUM_CH asynchronous input
// lines is synchronised, edge-detected and counted while a software gate
// window is open. When the window closes, all counts are snapshotted and
// streamed out one channel per valid/ready handshake.
//
// Parameters
//   NUM_CH       number of input channels (1..16)
//   WIDTH        counter width per channel (2..32)
//   SATURATE     1: counter sticks at all-ones on overflow, 0: wraps to zero
//   SYNC_STAGES  synchroniser flops per input (2..4)
//   CH_W         derived channel-index width; leave at default
//
// Ports
//   internalClock  system clock, rising edge
//   reset          asynchronous, active-high reset
//   sig_in         raw asynchronous edge inputs, one bit per channel
//   gate_start     single-cycle pulse, opens the counting window
//   gate_stop      single-cycle pulse, closes the counting window
//   busy           high whenever the block is not idle
//   out_valid      snapshot word available
//   out_ready      consumer accepts the current word
//   out_channel    channel index of the current word
//   out_count      snapshotted count of out_channel
//   out_overflow   channel overflowed during the window
//   out_last       current word belongs to channel NUM_CH-1
// ---------------------------------------------------------------------------
module edge_counter_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SATURATE    = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              internalClock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              gate_start,
  input  logic              gate_stop,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_channel,
  output logic [WIDTH-1:0]  out_count,
  output logic              out_overflow,
  output logic              out_last
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronisers and rising-edge detection
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] dly_q;
  logic [NUM_CH-1:0] rise;

  always_ff @(posedge internalClock or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      dly_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q      [NUM_CH];
  logic [WIDTH-1:0]  cnt_d      [NUM_CH];
  logic [WIDTH-1:0]  snap_q     [NUM_CH];
  logic [WIDTH-1:0]  snap_d     [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] snap_ovf_q, snap_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_channel_q, out_channel_d;

  // Candidate counter value for this cycle, i.e. the count with the current
  // rise folded in. Shared by the counting path and the stop-cycle snapshot
  // so an edge detected in the stop cycle is included in the snapshot.
  logic [WIDTH-1:0]  inc_val [NUM_CH];
  logic [NUM_CH-1:0] inc_ovf;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      inc_ovf[c] = 1'b0;
      inc_val[c] = cnt_q[c] + WIDTH'(rise[c]);
      if (rise[c] && (cnt_q[c] == '1)) begin
        inc_ovf[c] = 1'b1;
        inc_val[c] = (SATURATE != 0) ? cnt_q[c] : '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    snap_d        = snap_q;
    snap_ovf_d    = snap_ovf_q;
    out_valid_d   = out_valid_q;
    out_channel_d = out_channel_q;

    unique case (state_q)
      ST_IDLE: begin
        // gate_start has priority; a coincident gate_stop is dropped.
        if (gate_start) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = '0;
          end
          ovf_d   = '0;
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        cnt_d = inc_val;
        ovf_d = ovf_q | inc_ovf;
        if (gate_stop) begin
          snap_d        = inc_val;
          snap_ovf_d    = ovf_q | inc_ovf;
          out_channel_d = '0;
          out_valid_d   = 1'b1;
          state_d       = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_channel_q == LAST_CH) begin
            out_valid_d   = 1'b0;
            out_channel_d = '0;
            state_d       = ST_IDLE;
          end else begin
            out_channel_d = out_channel_q + CH_W'(1);
          end
        end
      end

      default: begin
        out_valid_d   = 1'b0;
        out_channel_d = '0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge internalClock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ovf_q         <= '0;
      snap_ovf_q    <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        snap_q[c] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ovf_q         <= ovf_d;
      snap_ovf_q    <= snap_ovf_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        snap_q[c] <= snap_d[c];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Word fields are masked with out_valid so the bus reads zero when idle,
  // rather than exposing stale snapshot contents from the previous window.
  assign busy         = (state_q != ST_IDLE);
  assign out_valid    = out_valid_q;
  assign out_channel  = out_channel_q;
  assign out_count    = out_valid_q ? snap_q[out_channel_q] : '0;
  assign out_overflow = out_valid_q & snap_ovf_q[out_channel_q];
  assign out_last     = out_valid_q & (out_channel_q == LAST_CH);

endmodule

// File: tb/tb_edge_counter_multi.sv
// ---------------------------------------------------------------------------
// tb_edge_counter_multi
//
// Self-checking bench. Three instances share clock, reset, gate, sig_in and
// out_ready: a default 16-bit instance and two 4-bit instances (saturating
// and wrapping). Expected words are pushed to per-instance queues when
// gate_stop is driven and popped when a handshake is observed.
// ---------------------------------------------------------------------------
module tb_edge_counter_multi;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sig_in = '0;
  logic           gate_start = 1'b0;
  logic           gate_stop = 1'b0;
  logic           out_ready = 1'b0;

  logic        busy0, valid0, ovf0, last0;
  logic [1:0]  ch0;
  logic [15:0] cnt0;
  logic        busy_s, valid_s, ovf_s, last_s;
  logic [1:0]  ch_s;
  logic [3:0]  cnt_s;
  logic        busy_w, valid_w, ovf_w, last_w;
  logic [1:0]  ch_w;
  logic [3:0]  cnt_w;

  edge_counter_multi #(.NUM_CH(NCH), .WIDTH(16), .SATURATE(1), .SYNC_STAGES(2)) u_dut (
    .internalClock(clk), .reset(rst), .sig_in(sig_in),
    .gate_start(gate_start), .gate_stop(gate_stop), .busy(busy0),
    .out_valid(valid0), .out_ready(out_ready), .out_channel(ch0),
    .out_count(cnt0), .out_overflow(ovf0), .out_last(last0)
  );

  edge_counter_multi #(.NUM_CH(NCH), .WIDTH(4), .SATURATE(1), .SYNC_STAGES(2)) u_sat (
    .internalClock(clk), .reset(rst), .sig_in(sig_in),
    .gate_start(gate_start), .gate_stop(gate_stop), .busy(busy_s),
    .out_valid(valid_s), .out_ready(out_ready), .out_channel(ch_s),
    .out_count(cnt_s), .out_overflow(ovf_s), .out_last(last_s)
  );

  edge_counter_multi #(.NUM_CH(NCH), .WIDTH(4), .SATURATE(0), .SYNC_STAGES(2)) u_wrap (
    .internalClock(clk), .reset(rst), .sig_in(sig_in),
    .gate_start(gate_start), .gate_stop(gate_stop), .busy(busy_w),
    .out_valid(valid_w), .out_ready(out_ready), .out_channel(ch_w),
    .out_count(cnt_w), .out_overflow(ovf_w), .out_last(last_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int cnt;
    bit ovf;
    bit last;
  } word_t;

  word_t q16[$];
  word_t qs[$];
  word_t qw[$];
  int    n[NCH];
  int    checks = 0;
  int    errors = 0;
  int    words_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int c, input bit counted);
    sig_in[c] = 1'b1;
    tick();
    tick();
    sig_in[c] = 1'b0;
    tick();
    tick();
    if (counted) n[c]++;
  endtask

  task automatic push_expected();
    word_t w;
    for (int c = 0; c < NCH; c++) begin
      w.ch   = c;
      w.last = (c == NCH - 1);
      w.cnt  = n[c];
      w.ovf  = 1'b0;
      q16.push_back(w);
      w.cnt  = (n[c] > 15) ? 15 : n[c];
      w.ovf  = (n[c] > 15);
      qs.push_back(w);
      w.cnt  = n[c] % 16;
      qw.push_back(w);
    end
  endtask

  task automatic start_gate();
    gate_start = 1'b1;
    tick();
    gate_start = 1'b0;
    for (int c = 0; c < NCH; c++) n[c] = 0;
    check("busy_after_start", busy0, 1);
  endtask

  task automatic stop_gate();
    push_expected();
    gate_stop = 1'b1;
    tick();
    gate_stop = 1'b0;
    check("valid_after_stop", valid0, 1);
    check("first_channel", ch0, 0);
  endtask

  task automatic drain(input bit rnd, input bit noise);
    int budget = 300;
    while (q16.size() > 0 && budget > 0) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        gate_start = 1'($urandom_range(0, 1));
        gate_stop  = 1'($urandom_range(0, 1));
      end
      tick();
      budget--;
    end
    out_ready  = 1'b0;
    gate_start = 1'b0;
    gate_stop  = 1'b0;
    check("drain_words_left", q16.size(), 0);
    check("busy_after_drain", busy0, 0);
    check("valid_after_drain", valid0, 0);
  endtask

  task automatic reset_and_check();
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_channel", ch0, 0);
    check("rst_count", cnt0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_last", last0, 0);
    check("rst_valid_sat", valid_s, 0);
    check("rst_valid_wrap", valid_w, 0);
    q16.delete();
    qs.delete();
    qw.delete();
    for (int c = 0; c < NCH; c++) n[c] = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor and stall-stability checker.
  logic        stall = 1'b0;
  logic [1:0]  st_ch;
  logic [15:0] st_cnt;
  logic        st_ovf, st_last;

  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", valid0, 1);
        check("stall_channel", ch0, st_ch);
        check("stall_count", cnt0, st_cnt);
        check("stall_overflow", ovf0, st_ovf);
        check("stall_last", last0, st_last);
      end
      if (valid0 && q16.size() == 0) check("unexpected_word", 1, 0);
      if (valid0 && out_ready && q16.size() > 0) begin
        e = q16.pop_front();
        check("d16_channel", ch0, e.ch);
        check("d16_count", cnt0, e.cnt);
        check("d16_overflow", ovf0, e.ovf);
        check("d16_last", last0, e.last);
        e = qs.pop_front();
        check("sat_valid", valid_s, 1);
        check("sat_channel", ch_s, e.ch);
        check("sat_count", cnt_s, e.cnt);
        check("sat_overflow", ovf_s, e.ovf);
        check("sat_last", last_s, e.last);
        e = qw.pop_front();
        check("wrap_valid", valid_w, 1);
        check("wrap_channel", ch_w, e.ch);
        check("wrap_count", cnt_w, e.cnt);
        check("wrap_overflow", ovf_w, e.ovf);
        check("wrap_last", last_w, e.last);
        words_seen++;
      end
      stall   = valid0 && !out_ready;
      st_ch   = ch0;
      st_cnt  = cnt0;
      st_ovf  = ovf0;
      st_last = last0;
    end
  end

  initial begin
    int base;
    int budget;

    // Reset state
    tick();
    check("reset_busy", busy0, 0);
    check("reset_valid", valid0, 0);
    check("reset_channel", ch0, 0);
    check("reset_count", cnt0, 0);
    check("reset_overflow", ovf0, 0);
    check("reset_last", last0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic window: 5 pulses on ch0, 3 on ch2
    start_gate();
    repeat (5) pulse(0, 1);
    repeat (3) pulse(2, 1);
    repeat (10) tick();
    stop_gate();
    drain(1'b0, 1'b0);

    // Overflow: 20 pulses on ch1
    start_gate();
    repeat (20) pulse(1, 1);
    repeat (3) tick();
    stop_gate();
    drain(1'b0, 1'b0);

    // Edges in IDLE ignored; edge whose rise lands in the stop cycle counted
    pulse(3, 0);
    pulse(3, 0);
    start_gate();
    pulse(3, 1);
    repeat (4) tick();
    sig_in[0] = 1'b1;
    tick();
    tick();
    n[0]++;
    stop_gate();
    sig_in[0] = 1'b0;
    drain(1'b0, 1'b0);

    // Edge one cycle too late for the stop cycle is excluded
    start_gate();
    repeat (4) tick();
    sig_in[0] = 1'b1;
    tick();
    stop_gate();
    sig_in[0] = 1'b0;
    drain(1'b0, 1'b0);

    // Back-pressure with gate noise during DRAIN
    start_gate();
    repeat (2) pulse(0, 1);
    pulse(3, 1);
    pulse(2, 1);
    repeat (4) tick();
    stop_gate();
    drain(1'b1, 1'b1);

    // Reset mid-COUNT, then a fresh window
    start_gate();
    repeat (3) pulse(1, 1);
    reset_and_check();
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    start_gate();
    repeat (2) pulse(2, 1);
    pulse(3, 1);
    repeat (3) tick();
    stop_gate();
    drain(1'b0, 1'b0);

    // Reset mid-DRAIN after two words
    start_gate();
    repeat (4) pulse(0, 1);
    pulse(1, 1);
    repeat (2) pulse(2, 1);
    repeat (3) pulse(3, 1);
    repeat (3) tick();
    stop_gate();
    base = words_seen;
    budget = 50;
    out_ready = 1'b1;
    while (words_seen - base < 2 && budget > 0) begin
      tick();
      budget--;
    end
    out_ready = 1'b0;
    check("partial_words", words_seen - base, 2);
    check("partial_valid", valid0, 1);
    check("partial_channel", ch0, 2);
    reset_and_check();
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    start_gate();
    pulse(0, 1);
    repeat (3) tick();
    stop_gate();
    drain(1'b0, 1'b0);

    // Simultaneous start and stop in IDLE: start wins
    gate_start = 1'b1;
    gate_stop  = 1'b1;
    tick();
    gate_start = 1'b0;
    gate_stop  = 1'b0;
    for (int c = 0; c < NCH; c++) n[c] = 0;
    check("both_busy", busy0, 1);
    check("both_no_valid", valid0, 0);
    repeat (5) tick();
    check("both_still_counting", busy0, 1);
    check("both_still_no_valid", valid0, 0);
    repeat (2) pulse(1, 1);
    repeat (3) tick();
    stop_gate();
    drain(1'b0, 1'b0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
